// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM state encodings
// and default widths.
package seq_gen_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10,
        ST_DONE   = 2'b11
    } seq_state_t;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register; msb presents the next bit to be transmitted.
module seq_shift_reg
    import seq_gen_pkg::*;
#(
    parameter int W = DEF_PAT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first (rep_cnt+1)
// times back-to-back. Define SEQ_GEN_PARITY_EN to append an even-parity bit per repetition.
//
//  state     | meaning
//  ----------+-------------------------------------------------------
//  ST_IDLE   | waiting for start; all outputs low
//  ST_SHIFT  | a pattern bit is on d_out; bit_idx is its position
//  ST_PARITY | parity bit of the captured pattern is on d_out
//  ST_DONE   | one-cycle done pulse, start ignored
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_cnt,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(PAT_W - 1);

    seq_state_t       state, state_nx;
    logic [BIT_W-1:0] bit_idx, bit_nx;
    logic [CNT_W-1:0] rep_left, rep_nx;
    logic [PAT_W-1:0] pat_q;
    logic             capture;
    logic             rep_end;

    logic             sr_load, sr_shift, sr_msb;
    logic [PAT_W-1:0] sr_val;

    logic             d_out_nx, d_valid_nx, busy_nx, done_nx;

    // The shifter is loaded one bit ahead: the MSB goes straight to d_out,
    // so the shifter's msb is always the bit for the following cycle.
    seq_shift_reg #(.W(PAT_W)) u_shift (
        .clock    (clock),
        .reset    (reset),
        .load     (sr_load),
        .shift    (sr_shift),
        .load_val (sr_val),
        .msb      (sr_msb)
    );

    always_comb begin
        state_nx   = state;
        bit_nx     = bit_idx;
        rep_nx     = rep_left;
        capture    = 1'b0;
        rep_end    = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_val     = {pat_q[PAT_W-2:0], 1'b0};
        d_out_nx   = 1'b0;
        d_valid_nx = 1'b0;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx   = ST_SHIFT;
                    capture    = 1'b1;
                    sr_load    = 1'b1;
                    sr_val     = {pattern[PAT_W-2:0], 1'b0};
                    bit_nx     = BIT_TOP;
                    rep_nx     = rep_cnt;
                    d_out_nx   = pattern[PAT_W-1];
                    d_valid_nx = 1'b1;
                    busy_nx    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_idx != '0) begin
                    bit_nx     = bit_idx - BIT_W'(1);
                    sr_shift   = 1'b1;
                    d_out_nx   = sr_msb;
                    d_valid_nx = 1'b1;
                    busy_nx    = 1'b1;
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    state_nx   = ST_PARITY;
                    d_out_nx   = ^pat_q;
                    d_valid_nx = 1'b1;
                    busy_nx    = 1'b1;
`else
                    rep_end    = 1'b1;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            ST_PARITY: begin
                rep_end = 1'b1;
            end
`endif
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // End of one repetition: restart from the captured pattern or finish.
        if (rep_end) begin
            if (rep_left != '0) begin
                rep_nx     = rep_left - CNT_W'(1);
                state_nx   = ST_SHIFT;
                bit_nx     = BIT_TOP;
                sr_load    = 1'b1;
                d_out_nx   = pat_q[PAT_W-1];
                d_valid_nx = 1'b1;
                busy_nx    = 1'b1;
            end else begin
                state_nx = ST_DONE;
                done_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            rep_left <= '0;
            pat_q    <= '0;
            d_out    <= 1'b0;
            d_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_idx  <= bit_nx;
            rep_left <= rep_nx;
            d_out    <= d_out_nx;
            d_valid  <= d_valid_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            if (capture) begin
                pat_q <= pattern;
            end
        end
    end

endmodule
